// File: rtl/adc_resp_pkg.sv
// Shared types and defaults for the 3-wire ADC link responder.
// Contents: FSM state enumeration, default parameter values, frame counter width.
package adc_resp_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 10;
  localparam int unsigned DEF_CHAN_BITS   = 3;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned FRAME_CNT_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_CMD,
    S_NULL,
    S_DATA,
    S_DONE
  } state_t;

endpackage

// File: rtl/adc_responder_if.sv
// Signal bundle between the serial ADC initiator side and the responder.
//   AdcCs/AdcClk/AdcDi : initiator pins (CS active low, serial clock, command bit)
//   AdcDo/AdcOe        : response bit and shared-line drive enable
//   ChanSel/ChanStrobe : sample request to the parallel channel source
//   ChanData           : sample returned by the channel source
//   FrameCnt/Abort     : completed-frame counter and mid-frame abort pulse
interface adc_responder_if
  import adc_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CHAN_BITS  = DEF_CHAN_BITS
) ();

  logic                   AdcCs;
  logic                   AdcClk;
  logic                   AdcDi;
  logic                   AdcDo;
  logic                   AdcOe;
  logic [CHAN_BITS-1:0]   ChanSel;
  logic                   ChanStrobe;
  logic [DATA_WIDTH-1:0]  ChanData;
  logic [FRAME_CNT_W-1:0] FrameCnt;
  logic                   Abort;

  modport slave (
    input  AdcCs, AdcClk, AdcDi, ChanData,
    output AdcDo, AdcOe, ChanSel, ChanStrobe, FrameCnt, Abort
  );

  modport master (
    output AdcCs, AdcClk, AdcDi, ChanData,
    input  AdcDo, AdcOe, ChanSel, ChanStrobe, FrameCnt, Abort
  );

endinterface

// File: rtl/adc_responder_sync_edge.sv
// Multi-stage synchronizer with reset preset value and rise/fall pulse outputs.
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous input pin
//   rise     : one-cycle pulse after a synchronized 0->1 transition
//   fall     : one-cycle pulse after a synchronized 1->0 transition
module sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [STAGES:0]   valid_q, valid_d;

  always_comb begin
    sync_d    = sync_q;
    valid_d   = valid_q;
    sync_d[0]  = d;
    valid_d[0] = 1'b1;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    for (int unsigned i = 1; i <= STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
      valid_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
    end
  end

  // Edges are only reported once both compared samples come from the pin
  // rather than the preset, so a pin already at the non-preset level when
  // reset releases does not look like a fresh edge.
  assign rise = valid_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
  assign fall = valid_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/adc_responder.sv
// Cycle-accurate responder for the 3-wire serial ADC link.
// Decodes start bit + channel select on AdcClk rises, requests a sample from
// the channel source, then drives a null bit and DATA_WIDTH data bits MSB
// first on AdcClk falls.
//   Clk, Reset : system clock, asynchronous active-high reset
//   bus        : adc_responder_if slave modport (pins, channel source, status)
module adc_responder
  import adc_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned CHAN_BITS   = DEF_CHAN_BITS,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic Clk,
  input  logic Reset,
  adc_responder_if.slave bus
);

  localparam int unsigned CNT_MAX = (DATA_WIDTH > CHAN_BITS) ? DATA_WIDTH : CHAN_BITS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic cs_rise, cs_fall, sclk_rise, sclk_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk (Clk), .rst (Reset), .d (bus.AdcCs), .rise (cs_rise), .fall (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
    .clk (Clk), .rst (Reset), .d (bus.AdcClk), .rise (sclk_rise), .fall (sclk_fall)
  );

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHAN_BITS-1:0]   cmd_q, cmd_d, cmd_shift;
  logic [CHAN_BITS-1:0]   chan_sel_q, chan_sel_d;
  logic                   strobe_q, strobe_d;
  logic                   load_q, load_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   do_q, do_d;
  logic                   oe_q, oe_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic                   abort_q, abort_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    chan_sel_d = chan_sel_q;
    strobe_d   = 1'b0;
    load_d     = strobe_q;
    shift_d    = shift_q;
    do_d       = do_q;
    oe_d       = oe_q;
    frame_d    = frame_q;
    abort_d    = 1'b0;
    cmd_shift  = (cmd_q << 1) | CHAN_BITS'(bus.AdcDi);

    // Sample is captured one Clk after the strobe pulse ends.
    if (load_q) begin
      shift_d = bus.ChanData;
    end

    case (state_q)
      S_IDLE: begin
        if (cs_fall) state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (sclk_rise && bus.AdcDi) begin
          state_d = S_CMD;
          cnt_d   = CNT_W'(CHAN_BITS - 1);
        end
      end
      S_CMD: begin
        if (sclk_rise) begin
          cmd_d = cmd_shift;
          if (cnt_q == '0) begin
            chan_sel_d = cmd_shift;
            strobe_d   = 1'b1;
            state_d    = S_NULL;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_NULL: begin
        // First fall drives the null bit, second fall presents the MSB.
        if (sclk_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
            do_d = 1'b0;
          end else begin
            do_d    = shift_q[DATA_WIDTH-1];
            shift_d = shift_q << 1;
            cnt_d   = CNT_W'(DATA_WIDTH - 1);
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sclk_fall) begin
          if (cnt_q == '0) begin
            oe_d    = 1'b0;
            do_d    = 1'b0;
            frame_d = frame_q + 1'b1;
            state_d = S_DONE;
          end else begin
            do_d    = shift_q[DATA_WIDTH-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase

    if (cs_rise) begin
      state_d    = S_IDLE;
      oe_d       = 1'b0;
      do_d       = 1'b0;
      strobe_d   = 1'b0;
      chan_sel_d = chan_sel_q;
      frame_d    = frame_q;
      abort_d    = (state_q == S_CMD) || (state_q == S_NULL) || (state_q == S_DATA);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      chan_sel_q <= '0;
      strobe_q   <= 1'b0;
      load_q     <= 1'b0;
      shift_q    <= '0;
      do_q       <= 1'b0;
      oe_q       <= 1'b0;
      frame_q    <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      chan_sel_q <= chan_sel_d;
      strobe_q   <= strobe_d;
      load_q     <= load_d;
      shift_q    <= shift_d;
      do_q       <= do_d;
      oe_q       <= oe_d;
      frame_q    <= frame_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.AdcDo      = do_q;
  assign bus.AdcOe      = oe_q;
  assign bus.ChanSel    = chan_sel_q;
  assign bus.ChanStrobe = strobe_q;
  assign bus.FrameCnt   = frame_q;
  assign bus.Abort      = abort_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: acts as the serial initiator and the
// channel source, checking decoded channel, line bits, strobes, aborts and
// the frame counter against hand-computed values.
module tb_adc_responder;

  localparam int PH = 4;  // Clk periods per AdcClk phase

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_responder_if #(.DATA_WIDTH(10), .CHAN_BITS(3)) bus ();

  adc_responder #(.DATA_WIDTH(10), .CHAN_BITS(3), .SYNC_STAGES(2)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;
  int strobe_cnt = 0;
  int abort_cnt  = 0;

  always @(negedge clk) begin
    if (bus.ChanStrobe === 1'b1) strobe_cnt++;
    if (bus.Abort === 1'b1) abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One AdcClk period; the response is sampled just before the rise.
  task automatic send_bit(input logic di, output logic so, output logic soe);
    so  = bus.AdcDo;
    soe = bus.AdcOe;
    bus.AdcDi  = di;
    bus.AdcClk = 1'b1;
    repeat (PH) @(negedge clk);
    bus.AdcClk = 1'b0;
    repeat (PH) @(negedge clk);
  endtask

  task automatic frame(input logic [2:0] ch, input logic [9:0] data, input int lead,
                       input int nbits, output logic [10:0] line, output logic [10:0] oes);
    logic s, e;
    line = '0;
    oes  = '0;
    bus.ChanData = data;
    bus.AdcCs    = 1'b0;
    repeat (PH) @(negedge clk);
    for (int i = 0; i < lead; i++) send_bit(1'b0, s, e);
    send_bit(1'b1, s, e);
    for (int i = 2; i >= 0; i--) send_bit(ch[i], s, e);
    for (int i = 0; i < nbits; i++) begin
      send_bit(1'b0, s, e);
      line = {line[9:0], s};
      oes  = {oes[9:0], e};
    end
  endtask

  task automatic cs_release();
    bus.AdcCs = 1'b1;
    repeat (2 * PH) @(negedge clk);
  endtask

  initial begin
    logic [10:0] line, oes;
    logic [4:0]  ex_oe;
    logic        ex_do, s, e;
    int          s0, a0;

    rst = 1'b1;
    bus.AdcCs    = 1'b1;
    bus.AdcClk   = 1'b0;
    bus.AdcDi    = 1'b0;
    bus.ChanData = '0;
    repeat (3) @(negedge clk);
    chk("rst_oe",     bus.AdcOe,      0);
    chk("rst_do",     bus.AdcDo,      0);
    chk("rst_chsel",  bus.ChanSel,    0);
    chk("rst_strobe", bus.ChanStrobe, 0);
    chk("rst_abort",  bus.Abort,      0);
    chk("rst_frame",  bus.FrameCnt,   0);
    rst = 1'b0;
    repeat (2 * PH) @(negedge clk);

    // Nominal read, channel 5, sample 2A5
    s0 = strobe_cnt; a0 = abort_cnt;
    frame(3'd5, 10'h2A5, 0, 11, line, oes);
    chk("nom_line",     line,             11'h2A5);
    chk("nom_oes",      oes,              11'h7FF);
    chk("nom_oe_after", bus.AdcOe,        0);
    chk("nom_chsel",    bus.ChanSel,      5);
    chk("nom_strobes",  strobe_cnt - s0,  1);
    chk("nom_frame",    bus.FrameCnt,     1);
    cs_release();
    chk("nom_no_abort", abort_cnt - a0,   0);

    // Leading zeros before start bit, channel 0
    frame(3'd0, 10'h155, 3, 11, line, oes);
    chk("lz_line",  line,         11'h155);
    chk("lz_chsel", bus.ChanSel,  0);
    chk("lz_frame", bus.FrameCnt, 2);
    cs_release();

    // Abort after null + 4 data bits
    a0 = abort_cnt;
    frame(3'd3, 10'h2F0, 0, 5, line, oes);
    chk("ab_line",   line,      11'h00B);
    chk("ab_oes",    oes,       11'h01F);
    chk("ab_oe_pre", bus.AdcOe, 1);
    bus.AdcCs = 1'b1;
    repeat (2) @(negedge clk);
    chk("ab_oe_hold", bus.AdcOe, 1);
    @(negedge clk);
    chk("ab_oe_clr",  bus.AdcOe, 0);
    repeat (PH) @(negedge clk);
    chk("ab_pulses", abort_cnt - a0, 1);
    chk("ab_frame",  bus.FrameCnt,   2);
    chk("ab_chsel",  bus.ChanSel,    3);
    repeat (PH) @(negedge clk);

    // Recovery frame
    frame(3'd6, 10'h3C1, 0, 11, line, oes);
    chk("rec_line",  line,         11'h3C1);
    chk("rec_chsel", bus.ChanSel,  6);
    chk("rec_frame", bus.FrameCnt, 3);
    cs_release();

    // Extra AdcClk pulses after the LSB
    s0 = strobe_cnt;
    frame(3'd2, 10'h001, 0, 11, line, oes);
    ex_oe = '0; ex_do = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, s, e);
      ex_oe = {ex_oe[3:0], e};
      ex_do = ex_do | s;
    end
    chk("ex_line",    line,            11'h001);
    chk("ex_oe",      ex_oe,           0);
    chk("ex_do",      ex_do,           0);
    chk("ex_strobes", strobe_cnt - s0, 1);
    chk("ex_frame",   bus.FrameCnt,    4);
    cs_release();

    // Reset mid-CMD with CS held low
    s0 = strobe_cnt; a0 = abort_cnt;
    bus.AdcCs = 1'b0;
    repeat (PH) @(negedge clk);
    send_bit(1'b1, s, e);
    send_bit(1'b1, s, e);
    rst = 1'b1;
    #1;
    chk("mr_chsel",  bus.ChanSel,    0);
    chk("mr_frame",  bus.FrameCnt,   0);
    chk("mr_oe",     bus.AdcOe,      0);
    chk("mr_do",     bus.AdcDo,      0);
    chk("mr_strobe", bus.ChanStrobe, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (PH) @(negedge clk);
    frame(3'd7, 10'h3FF, 0, 11, line, oes);
    chk("mr_idle_strobes", strobe_cnt - s0, 0);
    chk("mr_idle_oes",     oes,             0);
    chk("mr_idle_chsel",   bus.ChanSel,     0);
    chk("mr_idle_frame",   bus.FrameCnt,    0);
    chk("mr_no_abort",     abort_cnt - a0,  0);
    cs_release();

    // Fresh select after reset, then wrap over 256 frames
    frame(3'd1, 10'h2AA, 0, 11, line, oes);
    chk("fr_line",  line,         11'h2AA);
    chk("fr_chsel", bus.ChanSel,  1);
    chk("fr_frame", bus.FrameCnt, 1);
    cs_release();
    for (int k = 0; k < 254; k++) begin
      frame(3'(k), 10'(k * 3), 0, 11, line, oes);
      cs_release();
    end
    chk("wrap_255", bus.FrameCnt, 8'hFF);
    frame(3'd4, 10'h3FF, 0, 11, line, oes);
    cs_release();
    chk("wrap_line", line,         11'h3FF);
    chk("wrap_0",    bus.FrameCnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
